pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Owns the program counter for the MIPS fetch stage.
- Generates the select for the 2:1 next-PC mux: sequential PC+INC versus redirect target.
- Sequences stalls, branch/jump redirects and halt; holds a redirect that arrives while the pipeline is stalled.
- Pulses a flush for the IF/ID register on every applied redirect.

Parameters:
- len, 32, PC width in bits.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- INC, 4, sequential increment.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_stall  in  1  hazard unit stall; PC must hold.
- i_branch_taken  in  1  taken branch resolved in EX.
- i_branch_target  in  len  branch target address.
- i_jump  in  1  jump decoded in ID.
- i_jump_target  in  len  jump target address.
- i_halt  in  1  halt instruction decoded.
- o_pc  out  len  current PC, registered.
- o_pc_inc  out  len  o_pc + INC, combinational.
- o_mux_sel  out  1  next-PC mux select: 0 = sequential, 1 = redirect target; combinational.
- o_next_target  out  len  target presented to mux input b; combinational.
- o_flush  out  1  one-cycle IF/ID flush, registered.
- o_halted  out  1  high while in HALTED state.

Behaviour:
- Reset (async assert, sync deassert to first edge):
  - o_pc=RESET_PC, o_flush=0, o_halted=0.
  - o_mux_sel=0, pending register cleared, state RUN.
- Targets: low 2 bits forced to 0 before use; upper bits unmodified.
- Arithmetic: o_pc_inc = (o_pc + INC) mod 2^len; 32'hFFFF_FFFC wraps to 0, no flag.
- States: RUN, PEND, HALTED.
- Redirect priority, highest first:
  - live branch
  - pending redirect
  - live jump
  - The branch is the older instruction, so it wins over everything.
- RUN, i_stall=0:
  - If branch or jump is live: o_pc <= selected target, o_mux_sel=1, o_flush=1 next cycle.
  - Otherwise: o_pc <= o_pc_inc, o_mux_sel=0.
- RUN, i_stall=1:
  - o_pc holds, o_mux_sel=0.
  - A live redirect latches target and kind into pending; state -> PEND.
  - Otherwise stay in RUN.
- PEND, i_stall=1:
  - o_pc holds.
  - A live branch overwrites the pending entry.
  - A live jump overwrites only a pending jump, never a pending branch.
- PEND, i_stall=0:
  - Apply the highest-priority redirect (live branch, else pending) to o_pc; o_flush=1 next cycle.
  - Clear pending; state -> RUN.
  - A live jump in this cycle is discarded; the flush removes it.
- Halt:
  - i_halt with i_stall=0 and no applied redirect: o_pc holds, state -> HALTED, o_halted=1 from next cycle.
  - Redirect in the same cycle as halt: redirect applied, halt ignored, because the halt instruction is flushed.
  - i_halt while stalled or in PEND: ignored.
- HALTED:
  - o_pc frozen, o_mux_sel=0, o_flush=0.
  - All inputs ignored; exit only via reset.
- o_flush is high for exactly one cycle per applied redirect.
  - Back-to-back redirects in consecutive unstalled cycles give back-to-back flush pulses.
- Reset asserted mid-PEND or mid-HALTED: immediate return to the reset values; pending is lost.
- o_next_target = target of the redirect the sequencer would apply this cycle; 0 when none.

Test Plan:
- Reset release, no events, 4 cycles -> o_pc = 0,4,8,12; o_mux_sel=0; o_flush=0 throughout.
- At PC=0x10: branch target 0x100 with i_stall=0 -> o_mux_sel=1 that cycle; next cycle o_pc=0x100, o_flush=1 for one cycle; then o_pc=0x104.
- Stall 3 cycles at PC=0x20, jump to 0x200 in cycle 1, branch to 0x300 in cycle 2, stall drop in cycle 4 -> o_pc stays 0x20 during stall; o_pc=0x300 after the drop; single flush pulse.
- Branch 0x40 and jump 0x80 in the same unstalled cycle -> o_pc=0x40.
- Branch target 0x103 -> o_pc=0x100.
- Halt at PC=0x30 -> o_halted=1 and o_pc frozen at 0x30 despite later branch and jump inputs. Then i_rst_n=0 mid-cycle -> o_pc=0 immediately, o_halted=0.
- len=32, RESET_PC=32'hFFFF_FFF8 -> o_pc = FFFF_FFF8, FFFF_FFFC, 0000_0000; no other side effects.

Source files
------------

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - MIPS fetch-stage program counter sequencer
// Owns the PC, drives the next-PC mux select/target and flushes IF/ID on redirects.
module pc_sequencer #(
  parameter int              len      = 32,
  parameter logic [len-1:0]  RESET_PC = '0,
  parameter int              INC      = 4
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_stall,
  input  logic           i_branch_taken,
  input  logic [len-1:0] i_branch_target,
  input  logic           i_jump,
  input  logic [len-1:0] i_jump_target,
  input  logic           i_halt,
  output logic [len-1:0] o_pc,
  output logic [len-1:0] o_pc_inc,
  output logic           o_mux_sel,
  output logic [len-1:0] o_next_target,
  output logic           o_flush,
  output logic           o_halted
);

  typedef enum logic [1:0] {RUN, PEND, HALTED} state_t;

  localparam logic [len-1:0] INC_V      = len'(INC);
  localparam logic [len-1:0] ALIGN_MASK = ~len'(3);

  state_t         state_q, state_d;
  logic [len-1:0] pc_q, pc_d;
  logic [len-1:0] pend_tgt_q, pend_tgt_d;
  logic           pend_br_q, pend_br_d;
  logic           flush_q;
  logic           apply;
  logic [len-1:0] next_tgt;
  logic [len-1:0] br_tgt, jp_tgt;

  assign br_tgt   = i_branch_target & ALIGN_MASK;
  assign jp_tgt   = i_jump_target & ALIGN_MASK;
  assign o_pc_inc = pc_q + INC_V;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_tgt_d = pend_tgt_q;
    pend_br_d  = pend_br_q;
    apply      = 1'b0;
    next_tgt   = '0;
    case (state_q)
      RUN: begin
        if (!i_stall) begin
          if (i_branch_taken) begin
            apply    = 1'b1;
            next_tgt = br_tgt;
          end else if (i_jump) begin
            apply    = 1'b1;
            next_tgt = jp_tgt;
          end
          pc_d = apply ? next_tgt : o_pc_inc;
          // A redirect flushes the halt instruction, so halt only counts without one.
          if (!apply && i_halt) begin
            pc_d    = pc_q;
            state_d = HALTED;
          end
        end else if (i_branch_taken || i_jump) begin
          state_d    = PEND;
          pend_tgt_d = i_branch_taken ? br_tgt : jp_tgt;
          pend_br_d  = i_branch_taken;
        end
      end
      PEND: begin
        if (i_stall) begin
          if (i_branch_taken) begin
            pend_tgt_d = br_tgt;
            pend_br_d  = 1'b1;
          end else if (i_jump && !pend_br_q) begin
            pend_tgt_d = jp_tgt;
          end
        end else begin
          apply      = 1'b1;
          next_tgt   = i_branch_taken ? br_tgt : pend_tgt_q;
          pc_d       = next_tgt;
          state_d    = RUN;
          pend_tgt_d = '0;
          pend_br_d  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      pend_tgt_q <= '0;
      pend_br_q  <= 1'b0;
      flush_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_tgt_q <= pend_tgt_d;
      pend_br_q  <= pend_br_d;
      flush_q    <= apply;
    end
  end

  assign o_pc          = pc_q;
  assign o_mux_sel     = apply;
  assign o_next_target = next_tgt;
  assign o_flush       = flush_q;
  assign o_halted      = (state_q == HALTED);

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer
module tb_pc_sequencer;

  logic        clk;
  logic        rst_n;
  logic        stall, br, jp, halt;
  logic [31:0] bt, jt;
  logic [31:0] pc, pc_inc, tgt;
  logic        sel, flush, halted;

  logic [31:0] pc_b, pc_inc_b, tgt_b;
  logic        sel_b, flush_b, halted_b;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic        flush;
    logic        halted;
  } exp_t;
  exp_t sb[$];

  pc_sequencer dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall),
    .i_branch_taken(br), .i_branch_target(bt),
    .i_jump(jp), .i_jump_target(jt), .i_halt(halt),
    .o_pc(pc), .o_pc_inc(pc_inc), .o_mux_sel(sel),
    .o_next_target(tgt), .o_flush(flush), .o_halted(halted)
  );

  pc_sequencer #(.len(32), .RESET_PC(32'hFFFF_FFF8), .INC(4)) dut_wrap (
    .i_clk(clk), .i_rst_n(rst_n), .i_stall(1'b0),
    .i_branch_taken(1'b0), .i_branch_target(32'h0),
    .i_jump(1'b0), .i_jump_target(32'h0), .i_halt(1'b0),
    .o_pc(pc_b), .o_pc_inc(pc_inc_b), .o_mux_sel(sel_b),
    .o_next_target(tgt_b), .o_flush(flush_b), .o_halted(halted_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %08h exp %08h", tag, got, exp);
    end
  endtask

  task automatic step(input logic st, input logic b, input logic [31:0] btgt,
                      input logic j, input logic [31:0] jtgt, input logic h,
                      input logic exp_sel, input logic [31:0] exp_tgt,
                      input logic [31:0] exp_pc, input logic exp_fl, input logic exp_hl);
    exp_t e;
    stall = st; br = b; bt = btgt; jp = j; jt = jtgt; halt = h;
    #1;
    check("mux_sel", {31'b0, sel}, {31'b0, exp_sel});
    check("next_target", tgt, exp_tgt);
    sb.push_back('{exp_pc, exp_fl, exp_hl});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("pc", pc, e.pc);
    check("flush", {31'b0, flush}, {31'b0, e.flush});
    check("halted", {31'b0, halted}, {31'b0, e.halted});
  endtask

  logic [31:0] bexp [4];

  initial begin
    bexp = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    rst_n = 1'b0;
    stall = 0; br = 0; jp = 0; halt = 0; bt = 0; jt = 0;
    #1;
    check("rst_pc", pc, 32'h0);
    check("rst_flush", {31'b0, flush}, 32'h0);
    check("rst_halted", {31'b0, halted}, 32'h0);
    check("rst_sel", {31'b0, sel}, 32'h0);
    #6 rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      check("pc_inc", pc_inc, 32'(4 * i + 4));
      check("wrap_pc", pc_b, bexp[i]);
      check("wrap_pc_inc", pc_inc_b, bexp[i] + 32'd4);
      check("wrap_flush", {31'b0, flush_b}, 32'h0);
      step(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'(4 * i + 4), 0, 0);
    end

    step(0, 1, 32'h100, 0, 0, 0, 1, 32'h100, 32'h100, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h104, 0, 0);
    step(0, 0, 0, 1, 32'h20, 0, 1, 32'h20, 32'h20, 1, 0);

    step(1, 0, 0, 1, 32'h200, 0, 0, 32'h0, 32'h20, 0, 0);
    step(1, 1, 32'h300, 0, 0, 0, 0, 32'h0, 32'h20, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h20, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 32'h300, 32'h300, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h304, 0, 0);

    step(0, 1, 32'h40, 1, 32'h80, 0, 1, 32'h40, 32'h40, 1, 0);
    step(0, 1, 32'h103, 0, 0, 0, 1, 32'h100, 32'h100, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h104, 0, 0);

    step(1, 1, 32'h500, 0, 0, 0, 0, 32'h0, 32'h104, 0, 0);
    step(1, 0, 0, 1, 32'h600, 0, 0, 32'h0, 32'h104, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0, 32'h0, 32'h104, 0, 0);
    step(0, 0, 0, 1, 32'h700, 0, 1, 32'h500, 32'h500, 1, 0);

    step(1, 0, 0, 0, 0, 1, 0, 32'h0, 32'h500, 0, 0);
    step(0, 0, 0, 1, 32'h30, 1, 1, 32'h30, 32'h30, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0, 32'h0, 32'h30, 0, 1);
    step(0, 1, 32'h900, 1, 32'hA00, 0, 0, 32'h0, 32'h30, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h30, 0, 1);

    #3 rst_n = 1'b0;
    #1;
    check("async_rst_pc", pc, 32'h0);
    check("async_rst_halted", {31'b0, halted}, 32'h0);
    check("async_rst_flush", {31'b0, flush}, 32'h0);
    #2 rst_n = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h4, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
